// File: rtl/qed_dup_issue.sv
// SQED duplicating issue stage: passes originals through while buffering them,
// then replays the buffer as register/memory-remapped duplicates and tracks retirement.
module qed_dup_issue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [31:0]      ifu_qed_instruction,
  input  logic             exec_dup,
  input  logic             stall,
  input  logic             commit,
  output logic [31:0]      qed_ifu_instruction,
  output logic             qed_vld_out,
  output logic             qed_exec_dup,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic             qed_check_valid
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned CCW  = CNT_W + 1;
  localparam logic [31:0] NOP  = 32'h0000_007F;
  localparam logic [6:0]  OP_NOP = 7'b1111111;

  typedef enum logic [1:0] {
    S_ORIG = 2'd0,
    S_DUP  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   orig_cnt_q, orig_cnt_d;
  logic [CNT_W-1:0]   dup_cnt_q, dup_cnt_d;
  logic [CCW-1:0]     cmt_cnt_q, cmt_cnt_d;
  logic               chk_vld_q, chk_vld_d;

  logic               fifo_empty, fifo_full, issue, push;
  logic [31:0]        head, out_instr;

  // Remap nonzero register fields into x16-x31; memory ops move to the upper half.
  function automatic logic [31:0] remap(input logic [31:0] ins);
    logic [31:0] r;
    logic        f_rd, f_rs1, f_rs2, f_mem;
    r     = ins;
    f_rd  = 1'b0;
    f_rs1 = 1'b0;
    f_rs2 = 1'b0;
    f_mem = 1'b0;
    case (ins[6:0])
      7'b0110011: begin f_rd = 1'b1; f_rs1 = 1'b1; f_rs2 = 1'b1; end
      7'b0010011, 7'b0001111, 7'b1110011, 7'b1100111: begin
        f_rd = 1'b1; f_rs1 = 1'b1;
      end
      7'b0000011: begin f_rd = 1'b1; f_rs1 = 1'b1; f_mem = 1'b1; end
      7'b0100011: begin f_rs1 = 1'b1; f_rs2 = 1'b1; f_mem = 1'b1; end
      7'b1100011: begin f_rs1 = 1'b1; f_rs2 = 1'b1; end
      7'b0110111, 7'b0010111, 7'b1101111: f_rd = 1'b1;
      default: ;
    endcase
    if (f_rd  && (ins[11:7]  != 5'd0)) r[11] = 1'b1;
    if (f_rs1 && (ins[19:15] != 5'd0)) r[19] = 1'b1;
    if (f_rs2 && (ins[24:20] != 5'd0)) r[24] = 1'b1;
    if (f_mem) r[30] = 1'b1;
    return r;
  endfunction

  // Extra pointer bit separates full from empty when the indices coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign issue      = ena && !stall;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    orig_cnt_d = orig_cnt_q;
    dup_cnt_d  = dup_cnt_q;
    cmt_cnt_d  = cmt_cnt_q;
    chk_vld_d  = chk_vld_q;
    push       = 1'b0;
    out_instr  = ifu_qed_instruction;

    if (ena) begin
      case (state_q)
        S_ORIG: begin
          if (fifo_full) begin
            out_instr = NOP;
          end else if (issue && (ifu_qed_instruction[6:0] != OP_NOP)) begin
            push       = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            orig_cnt_d = orig_cnt_q + CNT_W'(1);
          end
          if (exec_dup && !fifo_empty) state_d = S_DUP;
        end
        S_DUP: begin
          out_instr = remap(head);
          if (issue) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            dup_cnt_d = dup_cnt_q + CNT_W'(1);
            if ((rd_ptr_q + PW'(1)) == wr_ptr_q) state_d = S_DONE;
          end
        end
        S_DONE: out_instr = NOP;
        default: begin
          out_instr = NOP;
          state_d   = S_ORIG;
        end
      endcase
    end

    // Retirements are counted regardless of enable or state.
    if (commit && (cmt_cnt_q != {CCW{1'b1}})) cmt_cnt_d = cmt_cnt_q + CCW'(1);

    if ((state_q == S_DONE) && (cmt_cnt_q == {orig_cnt_q, 1'b0})) chk_vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ORIG;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      orig_cnt_q <= '0;
      dup_cnt_q  <= '0;
      cmt_cnt_q  <= '0;
      chk_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      orig_cnt_q <= orig_cnt_d;
      dup_cnt_q  <= dup_cnt_d;
      cmt_cnt_q  <= cmt_cnt_d;
      chk_vld_q  <= chk_vld_d;
    end
  end

  // Buffer storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= ifu_qed_instruction;
  end

  assign qed_ifu_instruction = rst ? NOP : out_instr;
  assign qed_vld_out         = !rst && (out_instr[6:0] != OP_NOP);
  assign qed_exec_dup        = (state_q != S_ORIG);
  assign orig_cnt            = orig_cnt_q;
  assign dup_cnt             = dup_cnt_q;
  assign qed_check_valid     = chk_vld_q;

endmodule

// File: tb/tb_qed_dup_issue.sv
// Bench for qed_dup_issue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the issue/replay/retire behaviour.
module tb_qed_dup_issue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 2;
  localparam int          CMAX  = (1 << (CNT_W + 1)) - 1;
  localparam logic [31:0] NOP   = 32'h0000_007F;
  localparam logic [6:0]  OPS [12] = '{7'h33, 7'h13, 7'h03, 7'h0F, 7'h73, 7'h67,
                                       7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h5B};

  logic             clk = 1'b0;
  logic             rst, ena, exec_dup, stall, commit;
  logic [31:0]      ifu_qed_instruction;
  logic [31:0]      qed_ifu_instruction;
  logic             qed_vld_out, qed_exec_dup, qed_check_valid;
  logic [CNT_W-1:0] orig_cnt, dup_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = issuing originals, 1 = replaying, 2 = finished.
  logic [31:0] mq[$];
  int          mmode, ocnt, dcnt, ccnt;
  bit          mvalid;

  qed_dup_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ena                 (ena),
    .ifu_qed_instruction (ifu_qed_instruction),
    .exec_dup            (exec_dup),
    .stall               (stall),
    .commit              (commit),
    .qed_ifu_instruction (qed_ifu_instruction),
    .qed_vld_out         (qed_vld_out),
    .qed_exec_dup        (qed_exec_dup),
    .orig_cnt            (orig_cnt),
    .dup_cnt             (dup_cnt),
    .qed_check_valid     (qed_check_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Duplicate of an instruction: which fields move to the upper register bank.
  function automatic logic [31:0] dup_of(input logic [31:0] i);
    logic [31:0] r;
    bit          has_rd, has_rs1, has_rs2, is_mem;
    r       = i;
    has_rd  = i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h0F, 7'h73, 7'h67, 7'h37, 7'h17, 7'h6F};
    has_rs1 = i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h0F, 7'h73, 7'h67, 7'h23, 7'h63};
    has_rs2 = i[6:0] inside {7'h33, 7'h23, 7'h63};
    is_mem  = i[6:0] inside {7'h03, 7'h23};
    if (has_rd  && i[11:7]  != 0) r = r | 32'h0000_0800;
    if (has_rs1 && i[19:15] != 0) r = r | 32'h0008_0000;
    if (has_rs2 && i[24:20] != 0) r = r | 32'h0100_0000;
    if (is_mem) r = r + ((r & 32'h4000_0000) == 0 ? 32'h4000_0000 : 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    k = $urandom % 13;
    if (k == 12) return NOP;
    r = $urandom;
    r[6:0] = OPS[k];
    if ($urandom % 4 == 0) r[11:7]  = 5'd0;
    if ($urandom % 4 == 0) r[19:15] = 5'd0;
    if ($urandom % 4 == 0) r[24:20] = 5'd0;
    return r;
  endfunction

  task automatic check_outputs();
    logic [31:0] e;
    if (rst)                e = NOP;
    else if (!ena)          e = ifu_qed_instruction;
    else if (mmode == 0)    e = (mq.size() == DEPTH) ? NOP : ifu_qed_instruction;
    else if (mmode == 1)    e = dup_of(mq[0]);
    else                    e = NOP;
    chk("instr_out", qed_ifu_instruction, e);
    chk("vld_out", 32'(qed_vld_out), 32'(!rst && e[6:0] != 7'h7F));
    chk("exec_dup_out", 32'(qed_exec_dup), 32'(mmode != 0));
    chk("orig_cnt", 32'(orig_cnt), 32'(ocnt));
    chk("dup_cnt", 32'(dup_cnt), 32'(dcnt));
    chk("check_valid", 32'(qed_check_valid), 32'(mvalid));
  endtask

  task automatic drive(input bit r, input bit e, input logic [31:0] ins,
                       input bit xd, input bit st, input bit cm);
    @(negedge clk);
    rst = r; ena = e; ifu_qed_instruction = ins;
    exec_dup = xd; stall = st; commit = cm;
    #1;
    check_outputs();
  endtask

  task automatic advance();
    int sz;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mmode = 0; ocnt = 0; dcnt = 0; ccnt = 0; mvalid = 0;
    end else begin
      if (mmode == 2 && ccnt == 2 * ocnt) mvalid = 1;
      if (commit && ccnt < CMAX) ccnt++;
      if (ena) begin
        if (mmode == 0) begin
          sz = mq.size();
          if (!stall && sz < DEPTH && ifu_qed_instruction[6:0] != 7'h7F) begin
            mq.push_back(ifu_qed_instruction);
            ocnt++;
          end
          if (exec_dup && sz > 0) mmode = 1;
        end else if (mmode == 1 && !stall) begin
          void'(mq.pop_front());
          dcnt++;
          if (mq.size() == 0) mmode = 2;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [31:0] ins,
                      input bit xd, input bit st, input bit cm);
    drive(r, e, ins, xd, st, cm);
    advance();
  endtask

  initial begin
    rst = 1; ena = 1; ifu_qed_instruction = NOP; exec_dup = 0; stall = 0; commit = 0;
    mmode = 0; ocnt = 0; dcnt = 0; ccnt = 0; mvalid = 0;

    // ADDI original, duplicate, retirement of both
    step(1, 1, NOP, 0, 0, 0);
    step(1, 1, NOP, 0, 0, 0);
    drive(0, 1, 32'h0051_0093, 0, 0, 0);
    chk("addi_orig", qed_ifu_instruction, 32'h0051_0093);
    advance();
    step(0, 1, NOP, 1, 0, 0);
    drive(0, 1, NOP, 0, 0, 1);
    chk("addi_dup", qed_ifu_instruction, 32'h0059_0893);
    advance();
    drive(0, 1, NOP, 0, 0, 1);
    chk("addi_dup_cnt", 32'(dup_cnt), 32'd1);
    advance();
    step(0, 1, NOP, 0, 0, 0);
    drive(0, 1, NOP, 0, 0, 0);
    chk("addi_check_valid", 32'(qed_check_valid), 32'd1);
    advance();

    // LW duplicate lands in upper memory half
    step(1, 1, NOP, 0, 0, 0);
    step(0, 1, 32'h0000_2183, 0, 0, 0);
    step(0, 1, NOP, 1, 0, 0);
    drive(0, 1, NOP, 0, 0, 0);
    chk("lw_dup", qed_ifu_instruction, 32'h4000_2983);
    advance();

    // Stall during replay holds the head
    step(1, 1, NOP, 0, 0, 0);
    step(0, 1, 32'h0051_0093, 0, 0, 0);
    step(0, 1, 32'h0020_81B3, 0, 0, 0);
    step(0, 1, 32'h0051_2023, 1, 0, 0);
    step(0, 1, NOP, 0, 1, 0);
    step(0, 1, NOP, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, NOP, 0, 0, 0);
    drive(0, 1, NOP, 0, 0, 0);
    chk("stall_orig_cnt", 32'(orig_cnt), 32'd3);
    chk("stall_dup_cnt", 32'(dup_cnt), 32'd3);
    advance();

    // Ninth original is dropped when the buffer is full
    step(1, 1, NOP, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h0010_0093 + 32'(i << 20), 0, 0, 0);
    drive(0, 1, 32'h0090_0093, 0, 0, 0);
    chk("full_nop", qed_ifu_instruction, NOP);
    chk("full_vld", 32'(qed_vld_out), 32'd0);
    advance();
    drive(0, 1, NOP, 0, 0, 0);
    chk("full_orig_cnt", 32'(orig_cnt), 32'd8);
    advance();

    // Reset mid-replay, then exec_dup with an empty buffer
    step(1, 1, NOP, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h0020_8133, i == 3, 0, 0);
    step(0, 1, NOP, 0, 0, 0);
    step(0, 1, NOP, 0, 0, 0);
    step(1, 1, NOP, 0, 0, 0);
    drive(0, 1, 32'h0031_0193, 0, 0, 0);
    chk("rst_pass", qed_ifu_instruction, 32'h0031_0193);
    chk("rst_orig_cnt", 32'(orig_cnt), 32'd1 - 32'd1);
    advance();
    step(1, 1, NOP, 0, 0, 0);
    step(0, 1, NOP, 1, 0, 0);
    drive(0, 1, NOP, 0, 0, 0);
    chk("empty_dup_ignored", 32'(qed_exec_dup), 32'd0);
    advance();

    // Three of four retirements keep check_valid low; the fourth raises it
    step(1, 1, NOP, 0, 0, 0);
    step(0, 1, 32'h0051_0093, 0, 0, 1);
    step(0, 1, 32'h0020_81B3, 1, 0, 0);
    step(0, 1, NOP, 0, 0, 1);
    step(0, 1, NOP, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, NOP, 0, 0, 0);
    drive(0, 1, NOP, 0, 0, 0);
    chk("three_commits", 32'(qed_check_valid), 32'd0);
    advance();
    step(0, 1, NOP, 0, 0, 1);
    step(0, 1, NOP, 0, 0, 0);
    drive(0, 1, NOP, 0, 0, 0);
    chk("four_commits", 32'(qed_check_valid), 32'd1);
    advance();

    // Random traffic
    step(1, 1, NOP, 0, 0, 0);
    for (int c = 0; c < 5000; c++) begin
      bit r, e, xd, st, cm;
      r  = ($urandom % 300 == 0) || (mmode == 2 && $urandom % 15 == 0);
      e  = ($urandom % 10 != 0);
      xd = ($urandom % 20 == 0);
      st = ($urandom % 4 == 0);
      cm = ($urandom % 300 == 0) || (ccnt < 2 * ocnt && $urandom % 3 == 0);
      step(r, e, rand_instr(), xd, st, cm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
